// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - VGA sync stream decoder: position recovery, timing checks, lock FSM
// Optional saturating error counter on o_Err_Count when VGA_DEC_STATS_EN is defined.

module vga_sync_decoder #(
  parameter int TOTAL_COLS  = 800,
  parameter int TOTAL_ROWS  = 525,
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480,
  parameter int LOCK_FRAMES = 2,
  localparam int CW = $clog2(2*TOTAL_COLS),
  localparam int RW = $clog2(2*TOTAL_ROWS)
) (
  input  logic          i_Clk,
  input  logic          i_Rst_L,
  input  logic          i_HSync,
  input  logic          i_VSync,
  output logic [CW-1:0] o_Col_Count,
  output logic [RW-1:0] o_Row_Count,
  output logic          o_Active,
  output logic          o_Locked,
  output logic          o_Frame_Start,
  output logic          o_Line_Err,
  output logic          o_Frame_Err,
  output logic [7:0]    o_Err_Count
);

  localparam logic [CW-1:0] COL_MAX  = CW'(2*TOTAL_COLS - 1);
  localparam logic [CW-1:0] COL_PRE  = CW'(2*TOTAL_COLS - 2);
  localparam logic [CW-1:0] COL_LAST = CW'(TOTAL_COLS - 1);
  localparam logic [RW-1:0] ROW_MAX  = RW'(2*TOTAL_ROWS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(TOTAL_ROWS - 1);
  localparam logic [3:0]    GOOD_PRE = 4'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_UNLOCKED,
    ST_ACQUIRE,
    ST_LOCKED
  } state_t;

  state_t     state, state_nxt;
  logic       hs1, hs2, vs1, vs2;
  logic       h_edge, v_edge, timeout, line_bad, frame_bad_now;
  logic [3:0] good, good_nxt;
  logic       frame_bad, frame_bad_nxt;
  logic       line_err_nxt, frame_err_nxt;

  assign h_edge        = hs1 & ~hs2;
  assign v_edge        = vs1 & ~vs2;
  // Fires on the cycle the column counter is about to hit saturation, so the pulse lands with col = max.
  assign timeout       = !h_edge && (o_Col_Count == COL_PRE);
  assign line_bad      = (h_edge && (o_Col_Count != COL_LAST)) || timeout;
  assign frame_bad_now = v_edge && (o_Row_Count != ROW_LAST);

  assign o_Locked = (state == ST_LOCKED);
  assign o_Active = o_Locked && (o_Col_Count < CW'(ACTIVE_COLS)) && (o_Row_Count < RW'(ACTIVE_ROWS));

  always_comb begin
    state_nxt     = state;
    good_nxt      = good;
    frame_bad_nxt = frame_bad;
    line_err_nxt  = 1'b0;
    frame_err_nxt = 1'b0;
    case (state)
      ST_UNLOCKED: begin
        if (v_edge) begin
          state_nxt     = ST_ACQUIRE;
          good_nxt      = 4'd0;
          frame_bad_nxt = 1'b0;
        end
      end
      ST_ACQUIRE: begin
        line_err_nxt  = line_bad;
        frame_err_nxt = frame_bad_now;
        if (v_edge) begin
          // A frame counts only if nothing went wrong up to and including its closing edge.
          if (!frame_bad && !line_bad && !frame_bad_now) begin
            good_nxt = good + 4'd1;
            if (good == GOOD_PRE) state_nxt = ST_LOCKED;
          end else begin
            good_nxt = 4'd0;
          end
          frame_bad_nxt = 1'b0;
        end else if (line_bad) begin
          frame_bad_nxt = 1'b1;
          good_nxt      = 4'd0;
        end
      end
      ST_LOCKED: begin
        line_err_nxt  = line_bad;
        frame_err_nxt = frame_bad_now;
        if (line_bad || frame_bad_now) begin
          state_nxt     = ST_ACQUIRE;
          good_nxt      = 4'd0;
          frame_bad_nxt = !v_edge;
        end
      end
      default: state_nxt = ST_UNLOCKED;
    endcase
    if (timeout) begin
      state_nxt = ST_UNLOCKED;
      good_nxt  = 4'd0;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      hs1           <= 1'b0;
      hs2           <= 1'b0;
      vs1           <= 1'b0;
      vs2           <= 1'b0;
      o_Col_Count   <= '0;
      o_Row_Count   <= '0;
      state         <= ST_UNLOCKED;
      good          <= 4'd0;
      frame_bad     <= 1'b0;
      o_Line_Err    <= 1'b0;
      o_Frame_Err   <= 1'b0;
      o_Frame_Start <= 1'b0;
    end else begin
      hs1 <= i_HSync;
      hs2 <= hs1;
      vs1 <= i_VSync;
      vs2 <= vs1;
      if (h_edge) o_Col_Count <= '0;
      else if (o_Col_Count != COL_MAX) o_Col_Count <= o_Col_Count + 1'b1;
      if (v_edge) o_Row_Count <= '0;
      else if (h_edge && (o_Row_Count != ROW_MAX)) o_Row_Count <= o_Row_Count + 1'b1;
      state         <= state_nxt;
      good          <= good_nxt;
      frame_bad     <= frame_bad_nxt;
      o_Line_Err    <= line_err_nxt;
      o_Frame_Err   <= frame_err_nxt;
      o_Frame_Start <= v_edge;
    end
  end

`ifdef VGA_DEC_STATS_EN
  logic [7:0] err_count;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) err_count <= 8'd0;
    else if ((line_err_nxt || frame_err_nxt) && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
  end

  assign o_Err_Count = err_count;
`else
  assign o_Err_Count = 8'd0;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - scoreboard bench for vga_sync_decoder on a reduced 40x12 timing
// Expected events and positions are queued as the sync stream is driven and retired by a negedge monitor.

module tb_vga_sync_decoder;

  localparam int TC = 40;
  localparam int TR = 12;
  localparam int AC = 32;
  localparam int AR = 10;
  localparam int LF = 2;
  localparam int CW = $clog2(2*TC);
  localparam int RW = $clog2(2*TR);

  localparam int K_FS   = 0;
  localparam int K_LE   = 1;
  localparam int K_FE   = 2;
  localparam int K_LKUP = 3;
  localparam int K_LKDN = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          hsync = 1'b0;
  logic          vsync = 1'b0;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          active, locked, frame_start, line_err, frame_err;
  logic [7:0]    err_count;

  vga_sync_decoder #(
    .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR), .LOCK_FRAMES(LF)
  ) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_HSync(hsync), .i_VSync(vsync),
    .o_Col_Count(col), .o_Row_Count(row), .o_Active(active), .o_Locked(locked),
    .o_Frame_Start(frame_start), .o_Line_Err(line_err), .o_Frame_Err(frame_err),
    .o_Err_Count(err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; int kind; } ev_t;
  typedef struct { int due; int col; int row; } pos_t;
  ev_t  ev_q[$];
  pos_t pos_q[$];

  int vectors = 0;
  int miscompares = 0;

  // Stream-level expectation state
  int   st = 0;
  int   good = 0;
  bit   bad = 1'b0;
  int   last_rise = 0;
  int   h_cnt = 0;
  int   exp_errs = 0;
  logic prev_h = 1'b0;
  logic prev_v = 1'b0;

  task automatic check_val(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic string kname(input int k);
    case (k)
      K_FS:    return "frame_start";
      K_LE:    return "line_err";
      K_FE:    return "frame_err";
      K_LKUP:  return "lock_rise";
      default: return "lock_fall";
    endcase
  endfunction

  task automatic expect_ev(input int kind, input int due);
    ev_q.push_back('{due, kind});
  endtask

  task automatic drive(input logic h, input logic v);
    logic hr, vr, le, fe, to, err;
    int   d;
    @(posedge clk);
    #1;
    hsync = h;
    vsync = v;
    d  = cyc;
    hr = h & ~prev_h;
    vr = v & ~prev_v;
    prev_h = h;
    prev_v = v;
    to = !hr && ((d - last_rise) == 2*TC - 1);
    le = (hr && ((d - last_rise) != TC)) || to;
    fe = vr && (h_cnt != TR - 1);
    err = le || fe;
    if (hr) begin
      pos_q.push_back('{d + 1, ((d - 1 - last_rise) > 2*TC - 1) ? 2*TC - 1 : (d - 1 - last_rise), -1});
      last_rise = d;
    end
    if (vr) h_cnt = 0;
    else if (hr && h_cnt < 2*TR - 1) h_cnt++;
    if (hr || vr) pos_q.push_back('{d + 2, hr ? 0 : -1, h_cnt});
    if (vr) expect_ev(K_FS, d + 2);
    if (to) begin
      if (st != 0) begin
        expect_ev(K_LE, d + 2);
        exp_errs++;
      end
      if (st == 2) expect_ev(K_LKDN, d + 2);
      st = 0;
      good = 0;
    end else begin
      if (st != 0 && err) begin
        if (le) expect_ev(K_LE, d + 2);
        if (fe) expect_ev(K_FE, d + 2);
        exp_errs++;
      end
      case (st)
        0: if (vr) begin st = 1; good = 0; bad = 1'b0; end
        1: begin
          if (vr) begin
            if (!bad && !err) begin
              good++;
              if (good == LF) begin st = 2; expect_ev(K_LKUP, d + 2); end
            end else good = 0;
            bad = 1'b0;
          end else if (err) begin
            bad = 1'b1;
            good = 0;
          end
        end
        default: if (err) begin
          st = 1;
          good = 0;
          bad = !vr;
          expect_ev(K_LKDN, d + 2);
        end
      endcase
    end
  endtask

  task automatic run_frame(input int rows, input int short_row);
    for (int r = 0; r < rows; r++) begin
      int len;
      len = (r == short_row) ? TC - 1 : TC;
      for (int c = 0; c < len; c++) drive(c < AC, r < AR);
    end
  endtask

  task automatic hold_low(input int n);
    repeat (n) drive(1'b0, 1'b0);
  endtask

  task automatic burst(input int n);
    repeat (n) begin
      drive(1'b1, 1'b0);
      drive(1'b1, 1'b0);
      drive(1'b0, 1'b0);
      drive(1'b0, 1'b0);
    end
  endtask

  task automatic check_errs(input string tag);
    int e;
`ifdef VGA_DEC_STATS_EN
    e = (exp_errs > 255) ? 255 : exp_errs;
`else
    e = 0;
`endif
    check_val(tag, int'(err_count), e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, " col"}, int'(col), 0);
    check_val({tag, " row"}, int'(row), 0);
    check_val({tag, " active"}, int'(active), 0);
    check_val({tag, " locked"}, int'(locked), 0);
    check_val({tag, " frame_start"}, int'(frame_start), 0);
    check_val({tag, " line_err"}, int'(line_err), 0);
    check_val({tag, " frame_err"}, int'(frame_err), 0);
    check_val({tag, " err_count"}, int'(err_count), 0);
  endtask

  task automatic apply_reset(input string tag);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    hsync = 1'b0;
    vsync = 1'b0;
    #1;
    check_reset_outputs(tag);
    st = 0; good = 0; bad = 1'b0; h_cnt = 0; exp_errs = 0;
    prev_h = 1'b0; prev_v = 1'b0;
    ev_q.delete();
    pos_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Released counters read 0 as if an H edge had been driven two cycles earlier
    last_rise = cyc - 2;
  endtask

  // Monitor: retire queued expectations against what the DUT shows each cycle
  logic       prev_lk = 1'b0;
  logic [4:0] seen;
  int         act_cnt = 0;
  bit         act_valid = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_lk   = 1'b0;
      act_valid = 1'b0;
    end else begin
      seen = {!locked && prev_lk, locked && !prev_lk, frame_err, line_err, frame_start};
      prev_lk = locked;
      for (int k = 0; k < 5; k++) begin
        if (seen[k]) begin
          int idx;
          idx = -1;
          for (int i = 0; i < ev_q.size(); i++) if (idx < 0 && ev_q[i].kind == k) idx = i;
          if (idx >= 0) begin
            check_val({kname(k), " cycle"}, cyc, ev_q[idx].due);
            ev_q.delete(idx);
          end else begin
            check_val({"unexpected ", kname(k)}, 1, 0);
          end
        end
      end
      for (int i = ev_q.size() - 1; i >= 0; i--) begin
        if (ev_q[i].due <= cyc) begin
          check_val({kname(ev_q[i].kind), " missing"}, 0, 1);
          ev_q.delete(i);
        end
      end
      while (pos_q.size() > 0 && pos_q[0].due <= cyc) begin
        if (pos_q[0].col >= 0) check_val("col", int'(col), pos_q[0].col);
        if (pos_q[0].row >= 0) check_val("row", int'(row), pos_q[0].row);
        void'(pos_q.pop_front());
      end
      if (frame_start) begin
        if (act_valid) check_val("active_cycles", act_cnt, AC*AR);
        act_cnt   = 0;
        act_valid = locked;
      end
      if (!locked) act_valid = 1'b0;
      if (active) act_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset and release
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    last_rise = cyc - 2;

    // Clean stream: acquire, lock on third V edge, then one fully locked frame
    repeat (4) run_frame(TR, -1);

    // Short line while locked, then recovery over two clean frames
    run_frame(TR, 3);
    run_frame(TR, -1);
    run_frame(TR, -1);

    // Frame one line short: relocks, then frame error drops to acquire
    run_frame(TR - 1, -1);
    repeat (3) run_frame(TR, -1);

    // HSync stalled: one timeout, unlocked; restore and relock after three V edges
    hold_low(100);
    check_errs("err_count after timeout");
    repeat (3) run_frame(TR, -1);

    // Burst of short lines drives the error counter into saturation
    burst(300);
    hold_low(3);
    check_errs("err_count after burst");
    repeat (2) run_frame(TR, -1);
    run_frame(6, -1);

    // Reset mid-frame while locked, then first-edge latency on the restarted stream
    apply_reset("mid-frame reset");
    repeat (2) run_frame(TR, -1);
    hold_low(3);

    check_val("pending_events", ev_q.size(), 0);
    check_errs("err_count final");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
